// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Used by the receiver core and the baud tick generator.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int OVERSAMPLE    = 16;
  localparam int MID_SAMPLE    = 7;
  localparam int LAST_SAMPLE   = 15;
  localparam int DEF_DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every div clocks.
// The divisor is latched at each wrap so changes apply cleanly.
module uart_baud_tick #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] cnt;
  logic [W-1:0] div_q;
  logic [W-1:0] div_eff;
  logic         wrap;

  assign div_eff = (div == '0) ? W'(1) : div;
  assign wrap    = (cnt == div_q - W'(1));
  assign tick    = !clear && wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      div_q <= W'(1);
    end else if (clear || wrap) begin
      cnt   <= '0;
      div_q <= div_eff;
    end else begin
      cnt   <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with 16x oversampling and read-strobe status.
// Sticky flags clear on re; a completing byte wins over re.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int DATA_BITS = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 rx_en,
  input  logic                 rx,
  input  logic                 re,
  output logic [DATA_BITS-1:0] read_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  logic                 rx_m;
  logic                 rx_s;
  logic                 rx_d;
  state_t               state;
  state_t               state_nx;
  logic [SW-1:0]        samp_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick;
  logic                 clear;
  logic                 mid;
  logic                 last;
  logic                 done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign clear = (state == IDLE) || !rx_en;

  uart_baud_tick #(
    .W(DIV_W)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .div  (baud_div),
    .tick (tick)
  );

  assign mid  = tick && (samp_cnt == SW'(MID_SAMPLE));
  assign last = tick && (samp_cnt == SW'(LAST_SAMPLE));
  assign done = (state == STOP) && last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (rx_en && rx_d && !rx_s) state_nx = START;
      START: if (mid) state_nx = rx_s ? IDLE : DATA;
      DATA:  if (last && bit_cnt == BW'(DATA_BITS - 1)) state_nx = STOP;
      STOP:  if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (!rx_en) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      if (state_nx != state || !rx_en) samp_cnt <= '0;
      else if (tick)                   samp_cnt <= samp_cnt + SW'(1);
      if (state != DATA || !rx_en) bit_cnt <= '0;
      else if (last)               bit_cnt <= bit_cnt + BW'(1);
      // LSB arrives first, so shift right and fill from the top
      if (state == DATA && last) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (re) begin
        rx_valid  <= 1'b0;
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end
      if (done && rx_s) begin
        if (rx_valid && !re) begin
          overrun <= 1'b1;
        end else begin
          read_data <= shreg;
          rx_valid  <= 1'b1;
        end
      end
      if (done && !rx_s) frame_err <= 1'b1;
    end
  end

endmodule
